// File: rtl/dead_time_bridge_driver.sv
// H-bridge gate driver with per-leg dead-time insertion.
// Raw gate requests and the enable are synchronised. Each leg then runs a small
// FSM that keeps its high and low gates from ever conducting together. A
// shoot-through request (both gates of a leg at once) latches a fault. The
// fault holds the bridge off until it is cleared while the bridge is disabled.
module dead_time_bridge_driver #(
  parameter logic [7:0] DEAD_TIME   = 8'd25,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic [3:0] i_MOSFET,
  input  logic       i_enable,
  input  logic       i_fault_clear,
  output logic [3:0] o_MOSFET,
  output logic       o_fault,
  output logic [7:0] o_debug
);

  // Leg state codes are visible on o_debug, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_DT_H = 3'd1,
    ST_HIGH = 3'd2,
    ST_DT_L = 3'd3,
    ST_LOW  = 3'd4
  } leg_state_e;

  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_HIGH    = 2'd1,
    REQ_LOW     = 2'd2,
    REQ_ILLEGAL = 2'd3
  } leg_req_e;

  // The counter runs DEAD_TIME-1 down to 0, which gives DEAD_TIME dead cycles.
  localparam logic [7:0] DT_LOAD_C = DEAD_TIME - 8'd1;

  // Classify one leg's synchronised high/low request pair.
  function automatic leg_req_e decode_req(input logic hi, input logic lo);
    leg_req_e r;
    case ({hi, lo})
      2'b10:   r = REQ_HIGH;
      2'b01:   r = REQ_LOW;
      2'b11:   r = REQ_ILLEGAL;
      default: r = REQ_NONE;
    endcase
    return r;
  endfunction

  logic [4:0] sync_r [SYNC_STAGES];
  logic [3:0] mosfet_sync_s;
  logic       enable_sync_s;
  leg_req_e   req_s [2];
  logic       illegal_s;
  logic       force_off_s;
  leg_state_e state_r [2];
  leg_state_e state_nxt_s [2];
  logic [7:0] cnt_r [2];
  logic [7:0] cnt_nxt_s [2];
  logic       fault_r;
  logic       fault_nxt_s;
  logic [3:0] mosfet_r;

  assign {enable_sync_s, mosfet_sync_s} = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for {enable, gate requests}.
  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 5'b00000;
      end
    end else begin
      sync_r[0] <= {i_enable, i_MOSFET};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Decode leg requests. Bits [0]/[2] belong to leg A and bits [1]/[3] to leg B.
  always_comb begin
    req_s[0]    = decode_req(mosfet_sync_s[0], mosfet_sync_s[2]);
    req_s[1]    = decode_req(mosfet_sync_s[1], mosfet_sync_s[3]);
    illegal_s   = (req_s[0] == REQ_ILLEGAL) || (req_s[1] == REQ_ILLEGAL);
    force_off_s = illegal_s || fault_r || !enable_sync_s;
  end

  // Per-leg next state and dead-time counter.
  always_comb begin
    for (int leg = 0; leg < 2; leg++) begin
      state_nxt_s[leg] = state_r[leg];
      cnt_nxt_s[leg]   = cnt_r[leg];
      if (force_off_s) begin
        // A disable or fault turns gates off at once, with no dead time.
        state_nxt_s[leg] = ST_OFF;
        cnt_nxt_s[leg]   = 8'd0;
      end else begin
        case (state_r[leg])
          ST_OFF: begin
            if (req_s[leg] == REQ_HIGH) begin
              state_nxt_s[leg] = ST_DT_H;
              cnt_nxt_s[leg]   = DT_LOAD_C;
            end else if (req_s[leg] == REQ_LOW) begin
              state_nxt_s[leg] = ST_DT_L;
              cnt_nxt_s[leg]   = DT_LOAD_C;
            end else begin
              state_nxt_s[leg] = ST_OFF;
              cnt_nxt_s[leg]   = 8'd0;
            end
          end
          ST_HIGH: begin
            if (req_s[leg] == REQ_HIGH) begin
              state_nxt_s[leg] = ST_HIGH;
            end else begin
              state_nxt_s[leg] = ST_DT_L;
              cnt_nxt_s[leg]   = DT_LOAD_C;
            end
          end
          ST_LOW: begin
            if (req_s[leg] == REQ_LOW) begin
              state_nxt_s[leg] = ST_LOW;
            end else begin
              state_nxt_s[leg] = ST_DT_H;
              cnt_nxt_s[leg]   = DT_LOAD_C;
            end
          end
          ST_DT_H, ST_DT_L: begin
            // The destination is chosen only when the dead time expires, so
            // request glitches inside the window do not restart it.
            if (cnt_r[leg] == 8'd0) begin
              case (req_s[leg])
                REQ_HIGH: state_nxt_s[leg] = ST_HIGH;
                REQ_LOW:  state_nxt_s[leg] = ST_LOW;
                default:  state_nxt_s[leg] = ST_OFF;
              endcase
            end else begin
              cnt_nxt_s[leg] = cnt_r[leg] - 8'd1;
            end
          end
          default: begin
            state_nxt_s[leg] = ST_OFF;
            cnt_nxt_s[leg]   = 8'd0;
          end
        endcase
      end
    end
  end

  // Fault latch. A new shoot-through request beats a simultaneous clear.
  always_comb begin
    fault_nxt_s = fault_r;
    if (illegal_s) begin
      fault_nxt_s = 1'b1;
    end else if (i_fault_clear && !enable_sync_s) begin
      fault_nxt_s = 1'b0;
    end else begin
      fault_nxt_s = fault_r;
    end
  end

  // Leg FSM, counter and fault registers.
  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) begin
      for (int leg = 0; leg < 2; leg++) begin
        state_r[leg] <= ST_OFF;
        cnt_r[leg]   <= 8'd0;
      end
      fault_r <= 1'b0;
    end else begin
      for (int leg = 0; leg < 2; leg++) begin
        state_r[leg] <= state_nxt_s[leg];
        cnt_r[leg]   <= cnt_nxt_s[leg];
      end
      fault_r <= fault_nxt_s;
    end
  end

  // Registered gate drive. Only HIGH and LOW states ever drive a gate.
  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) begin
      mosfet_r <= 4'b0000;
    end else begin
      mosfet_r <= {state_r[1] == ST_LOW,  state_r[0] == ST_LOW,
                   state_r[1] == ST_HIGH, state_r[0] == ST_HIGH};
    end
  end

  assign o_MOSFET = mosfet_r;
  assign o_fault  = fault_r;
  assign o_debug  = {state_r[1], state_r[0], fault_r, enable_sync_s};

endmodule

// File: tb/tb_dead_time_bridge_driver.sv
// Self-checking bench for dead_time_bridge_driver (DEAD_TIME=4, SYNC_STAGES=2).
module tb_dead_time_bridge_driver;

  localparam int DT   = 4;
  localparam int SYNC = 2;

  logic       i_clock;
  logic       i_RESET;
  logic [3:0] i_MOSFET;
  logic       i_enable;
  logic       i_fault_clear;
  logic [3:0] o_MOSFET;
  logic       o_fault;
  logic [7:0] o_debug;

  int total;
  int bad;

  // Reference model: delay line plus, per leg, the conducting side
  // (0 none, 1 high, 2 low) and the remaining dead cycles.
  logic [4:0] m_pipe [SYNC];
  int         m_drive [2];
  int         m_dead [2];
  logic [3:0] m_out;
  logic       m_fault;
  logic       m_en_sync;

  dead_time_bridge_driver #(.DEAD_TIME(8'd4), .SYNC_STAGES(2)) dut (
    .i_clock      (i_clock),
    .i_RESET      (i_RESET),
    .i_MOSFET     (i_MOSFET),
    .i_enable     (i_enable),
    .i_fault_clear(i_fault_clear),
    .o_MOSFET     (o_MOSFET),
    .o_fault      (o_fault),
    .o_debug      (o_debug)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  function automatic int req_of(input logic h, input logic l);
    if (h && !l) return 1;
    if (!h && l) return 2;
    if (h && l) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 5'b00000;
    for (int i = 0; i < 2; i++) begin
      m_drive[i] = 0;
      m_dead[i]  = 0;
    end
    m_out     = 4'b0000;
    m_fault   = 1'b0;
    m_en_sync = 1'b0;
  endtask

  task automatic model_edge();
    logic [4:0] s;
    logic       en;
    int         req [2];
    logic       ill;
    logic [3:0] nxt_out;
    s = m_pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = {i_enable, i_MOSFET};
    m_en_sync = m_pipe[SYNC-1][4];
    en = s[4];
    req[0] = req_of(s[0], s[2]);
    req[1] = req_of(s[1], s[3]);
    ill = (req[0] == 3) || (req[1] == 3);
    nxt_out = {m_drive[1] == 2, m_drive[0] == 2, m_drive[1] == 1, m_drive[0] == 1};
    for (int g = 0; g < 2; g++) begin
      if (ill || m_fault || !en) begin
        m_drive[g] = 0;
        m_dead[g]  = 0;
      end else if (m_dead[g] > 0) begin
        m_dead[g] = m_dead[g] - 1;
        if (m_dead[g] == 0) m_drive[g] = req[g];
      end else if (m_drive[g] != req[g]) begin
        m_drive[g] = 0;
        m_dead[g]  = DT;
      end
    end
    if (ill) m_fault = 1'b1;
    else if (i_fault_clear && !en) m_fault = 1'b0;
    m_out = nxt_out;
  endtask

  task automatic check(input string tag);
    total++;
    assert (o_MOSFET === m_out) else begin
      bad++;
      $error("FAIL %s o_MOSFET got=%b exp=%b", tag, o_MOSFET, m_out);
    end
    total++;
    assert (o_fault === m_fault) else begin
      bad++;
      $error("FAIL %s o_fault got=%b exp=%b", tag, o_fault, m_fault);
    end
    total++;
    assert (o_debug[1:0] === {m_fault, m_en_sync}) else begin
      bad++;
      $error("FAIL %s o_debug[1:0] got=%b exp=%b", tag, o_debug[1:0], {m_fault, m_en_sync});
    end
    total++;
    assert (((o_MOSFET[0] & o_MOSFET[2]) | (o_MOSFET[1] & o_MOSFET[3])) === 1'b0) else begin
      bad++;
      $error("FAIL %s shoot_through got=%b exp=no overlap", tag, o_MOSFET);
    end
  endtask

  task automatic expect_val(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge i_clock);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic pulse_reset(input string tag);
    i_RESET = 1'b1;
    #2;
    expect_val({tag, "_mosfet"}, {4'h0, o_MOSFET}, 8'h00);
    expect_val({tag, "_fault"}, {7'h00, o_fault}, 8'h00);
    expect_val({tag, "_debug"}, o_debug, 8'h00);
    model_reset();
    i_RESET = 1'b0;
  endtask

  initial begin
    int         hold;
    int         la;
    int         lb;
    logic [3:0] raw;
    total = 0;
    bad   = 0;
    model_reset();
    i_RESET       = 1'b1;
    i_MOSFET      = 4'b0000;
    i_enable      = 1'b0;
    i_fault_clear = 1'b0;
    #12;
    expect_val("reset_mosfet", {4'h0, o_MOSFET}, 8'h00);
    expect_val("reset_fault", {7'h00, o_fault}, 8'h00);
    expect_val("reset_debug", o_debug, 8'h00);
    i_RESET = 1'b0;

    i_enable = 1'b1;
    repeat (4) tick("idle");

    // Turn-on from OFF: 3 latency + 4 dead cycles of zero, then 1001.
    i_MOSFET = 4'b1001;
    for (int k = 1; k <= 7; k++) begin
      tick("turn_on");
      expect_val("turn_on_zero", {4'h0, o_MOSFET}, 8'h00);
    end
    tick("turn_on");
    expect_val("turn_on_1001", {4'h0, o_MOSFET}, 8'h09);
    repeat (3) tick("hold_1001");

    // Reversal 1001 -> 0110.
    i_MOSFET = 4'b0110;
    for (int k = 1; k <= 3; k++) begin
      tick("reverse");
      expect_val("reverse_old", {4'h0, o_MOSFET}, 8'h09);
    end
    for (int k = 4; k <= 7; k++) begin
      tick("reverse");
      expect_val("reverse_dead", {4'h0, o_MOSFET}, 8'h00);
    end
    tick("reverse");
    expect_val("reverse_0110", {4'h0, o_MOSFET}, 8'h06);

    // Leg A glitch while HIGH: dead window is not restarted, low gate stays off.
    i_MOSFET = 4'b1001;
    repeat (10) tick("back_1001");
    i_MOSFET = 4'b1000;
    tick("glitch");
    expect_val("glitch_a_low", {7'h00, o_MOSFET[2]}, 8'h00);
    i_MOSFET = 4'b1001;
    for (int k = 0; k < 10; k++) begin
      tick("glitch");
      expect_val("glitch_a_low", {7'h00, o_MOSFET[2]}, 8'h00);
    end
    expect_val("glitch_end", {4'h0, o_MOSFET}, 8'h09);

    // Shoot-through request on leg A.
    i_MOSFET = 4'b0101;
    repeat (3) tick("illegal");
    expect_val("illegal_fault", {7'h00, o_fault}, 8'h01);
    tick("illegal");
    expect_val("illegal_off", {4'h0, o_MOSFET}, 8'h00);
    i_MOSFET = 4'b0000;
    repeat (3) tick("fault_hold");
    i_fault_clear = 1'b1;
    tick("clear_enabled");
    i_fault_clear = 1'b0;
    tick("clear_enabled");
    expect_val("clear_ignored", {7'h00, o_fault}, 8'h01);
    i_enable = 1'b0;
    repeat (3) tick("disable");
    i_fault_clear = 1'b1;
    tick("clear_disabled");
    i_fault_clear = 1'b0;
    expect_val("clear_taken", {7'h00, o_fault}, 8'h00);

    // Enable dropped during leg B DT_H; re-enable restarts full dead time.
    i_enable = 1'b1;
    repeat (4) tick("reenable");
    i_MOSFET = 4'b0010;
    repeat (4) tick("b_dt_h");
    i_enable = 1'b0;
    repeat (3) tick("b_disable");
    expect_val("b_disable_off", {4'h0, o_MOSFET}, 8'h00);
    i_enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick("b_restart");
      expect_val("b_restart_zero", {4'h0, o_MOSFET}, 8'h00);
    end
    tick("b_restart");
    expect_val("b_restart_0010", {4'h0, o_MOSFET}, 8'h02);

    // Reset in the middle of DT_L on leg B.
    i_MOSFET = 4'b1000;
    repeat (4) tick("b_dt_l");
    pulse_reset("rst_dt");
    repeat (7) tick("after_rst_dt");
    tick("after_rst_dt");
    expect_val("after_rst_dt_1000", {4'h0, o_MOSFET}, 8'h08);

    // Reset while the fault is latched.
    i_MOSFET = 4'b1111;
    repeat (4) tick("fault2");
    expect_val("fault2_set", {7'h00, o_fault}, 8'h01);
    pulse_reset("rst_fault");
    i_MOSFET = 4'b1000;
    repeat (8) tick("after_rst_fault");
    expect_val("after_rst_fault_1000", {4'h0, o_MOSFET}, 8'h08);

    // Randomised segments against the model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        raw = 4'($urandom);
        i_MOSFET = raw;
      end else begin
        la = $urandom_range(0, 2);
        lb = $urandom_range(0, 2);
        i_MOSFET = {lb == 2, la == 2, lb == 1, la == 1};
      end
      i_enable = ($urandom_range(0, 5) != 0);
      hold = $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) begin
        i_fault_clear = (k == 3) && ($urandom_range(0, 1) == 1);
        tick("random");
      end
      i_fault_clear = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
